ddr3_ddl_cmd: RTL and testbench
===============================

# ddr3_ddl_cmd

Command-issue stage at the controller/DFI end of the `ddl_*` link. It accepts one DDR3 command per valid/ready handshake from `ddr3_fsm` and drives it onto the SDRAM command pins for exactly one cycle. It then holds off the next command for the command's minimum spacing and enforces write recovery before PRECHARGE/REFRESH. It also emits read/write strobes with the transaction ID to the data path.

## Interface
Parameters:
- DDR_ROW_BITS, 13, address bus width (row/column/MRS operand)
- REQID, 4, transaction-ID width
- CYCLES_RCD, 2, ACT to next command
- CYCLES_RP, 2, PRE to next command
- CYCLES_CCD, 4, RD/WR to next command
- CYCLES_WR, 10, WR command to earliest PRE/REF (write recovery)
- CYCLES_RFC, 11, REF to next command
- CYCLES_MRD, 4, MRS to next command
- CYCLES_ZQ, 64, ZQCL to next command

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- ddl_req_i  in  1  command valid
- ddl_rdy_o  out  1  command ready; transfer when req & rdy
- ddl_cmd_i  in  3  {ras_n,cas_n,we_n}: 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS, 110 ZQCL
- ddl_tid_i  in  REQID  transaction ID (RD/WR only)
- ddl_ba_i  in  3  bank address
- ddl_adr_i  in  DDR_ROW_BITS  row/column/mode operand
- dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o  out  1 each  SDRAM command pins
- dfi_ba_o  out  3  bank pins
- dfi_adr_o  out  DDR_ROW_BITS  address pins
- dfi_rden_o  out  1  pulse: RD on pins this cycle
- dfi_wren_o  out  1  pulse: WR on pins this cycle
- dfi_tid_o  out  REQID  ID for the RD/WR on pins this cycle

## Operation
- State machine: IDLE (spacing counter zero) and WAIT (counter non-zero). The separate write-recovery counter runs in both states.
- Accept: in IDLE, with ddl_req_i & ddl_rdy_o at edge t:
  - pins at t+1 get cs_n=0, {ras_n,cas_n,we_n}=ddl_cmd_i, ba and adr as given.
  - for any command other than NOP, the spacing counter loads D-1, where D is RCD, CCD, CCD, RP, RFC, MRD or ZQ for ACT, RD, WR, PRE, REF, MRS or ZQCL.
  - if D-1>0, go to WAIT.
- NOP accepted: cs_n stays 1 and the counter is not loaded (D=1).
- WAIT: the counter decrements each cycle. Go to IDLE when the counter reaches 0.
- Write recovery: WR acceptance loads wr_cnt=CYCLES_WR-1. wr_cnt decrements to 0 independently, and a new WR reloads it.
- ddl_rdy_o = IDLE & !((cmd==PRE | cmd==REF) & wr_cnt!=0). It depends combinationally on ddl_cmd_i; the initiator must hold cmd stable while req is high.
- dfi_rden_o/dfi_wren_o pulse high in the same cycle RD/WR drive the pins, with dfi_tid_o = accepted tid. Otherwise both are 0 and dfi_tid_o holds its last value.
- Counter widths are $clog2(max parameter + 1). All CYCLES_* must be ≥1.

## Timing
- Reset (reset_n=0 at an edge), next cycle:
  - cs_n/ras_n/cas_n/we_n=1, ba=0, adr=0, rden=wren=0, tid=0.
  - both counters=0 and the state is IDLE; ddl_rdy_o=0 while reset_n=0.
- Reset mid-WAIT aborts the spacing and write recovery immediately, with no command driven.
- Command-to-pins latency is 1 cycle. The pins return to cs_n=1 (NOP) in the following cycle unless a back-to-back accept occurs (D=1).
- Two accepted commands appear on the pins exactly D cycles apart. They appear no fewer than D apart if req was low.
- WR accepted at t: a PRE/REF is accepted no earlier than t+CYCLES_WR, even if the spacing has expired. ACT/RD/WR/MRS to other banks are not blocked by wr_cnt.
- req low while IDLE: the pins show NOP and the counters are unaffected.
- Holding a PRE while wr_cnt>0 stalls the link. The initiator may withdraw it; no ordering change occurs inside the block.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with req=1 → no cs_n=0 pulse; ddl_rdy_o=0; release → rdy=1 in the first cycle after.
- ACT(ba=2, row=0x155) then RD(col=0x008, tid=5) held valid → ACT on the pins at t+1, RD on the pins at t+3; rden=1 with tid=5 on the RD cycle only.
- RD, RD, WR back-to-back (tids 1,2,3) → pins 4 cycles apart; rdy low for 3 cycles after each accept.
- WR at t, then PRE held valid → PRE accepted at t+10, pins at t+11; an ACT to another bank presented at t+4 is accepted at t+4.
- REF then ZQCL → ZQCL accepted 11 cycles after REF; the next command accepted 64 cycles after ZQCL.
- Assert reset_n=0 3 cycles into REF spacing, release → the next ACT is accepted the first cycle after release, with no residual wait.

Source files
------------

// File: rtl/ddr3_ddl_cmd.sv
// rtl/ddr3_ddl_cmd.sv - DDR3 command-issue stage with spacing and write-recovery timers
//
// Ports:
//   clock, reset_n           system clock, synchronous active-low reset
//   ddl_req_i / ddl_rdy_o    command handshake from ddr3_fsm
//   ddl_cmd_i                {ras_n,cas_n,we_n} of the offered command
//   ddl_tid_i                transaction ID (RD/WR)
//   ddl_ba_i, ddl_adr_i      bank and row/column/mode operand
//   dfi_cs_n_o .. dfi_we_n_o SDRAM command pins, registered
//   dfi_ba_o, dfi_adr_o      SDRAM bank/address pins, registered
//   dfi_rden_o, dfi_wren_o   one-cycle strobes aligned with RD/WR on the pins
//   dfi_tid_o                ID of the RD/WR on the pins, held otherwise
module ddr3_ddl_cmd #(
  parameter int DDR_ROW_BITS = 13,
  parameter int REQID        = 4,
  parameter int CYCLES_RCD   = 2,
  parameter int CYCLES_RP    = 2,
  parameter int CYCLES_CCD   = 4,
  parameter int CYCLES_WR    = 10,
  parameter int CYCLES_RFC   = 11,
  parameter int CYCLES_MRD   = 4,
  parameter int CYCLES_ZQ    = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ddl_req_i,
  output logic                    ddl_rdy_o,
  input  logic [2:0]              ddl_cmd_i,
  input  logic [REQID-1:0]        ddl_tid_i,
  input  logic [2:0]              ddl_ba_i,
  input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
  output logic                    dfi_cs_n_o,
  output logic                    dfi_ras_n_o,
  output logic                    dfi_cas_n_o,
  output logic                    dfi_we_n_o,
  output logic [2:0]              dfi_ba_o,
  output logic [DDR_ROW_BITS-1:0] dfi_adr_o,
  output logic                    dfi_rden_o,
  output logic                    dfi_wren_o,
  output logic [REQID-1:0]        dfi_tid_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = max2(max2(max2(CYCLES_RCD, CYCLES_RP), max2(CYCLES_CCD, CYCLES_WR)),
                             max2(max2(CYCLES_RFC, CYCLES_MRD), CYCLES_ZQ));
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_ACT  = 3'b011;
  localparam logic [2:0] CMD_RD   = 3'b101;
  localparam logic [2:0] CMD_WR   = 3'b100;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_REF  = 3'b001;
  localparam logic [2:0] CMD_MRS  = 3'b000;
  localparam logic [2:0] CMD_ZQCL = 3'b110;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] dly_m1;
  logic          wr_block;
  logic          accept;

  // Spacing minus one: the accept cycle itself counts as the first cycle.
  always_comb begin
    dly_m1 = '0;
    case (ddl_cmd_i)
      CMD_ACT:  dly_m1 = CW'(CYCLES_RCD - 1);
      CMD_RD:   dly_m1 = CW'(CYCLES_CCD - 1);
      CMD_WR:   dly_m1 = CW'(CYCLES_CCD - 1);
      CMD_PRE:  dly_m1 = CW'(CYCLES_RP - 1);
      CMD_REF:  dly_m1 = CW'(CYCLES_RFC - 1);
      CMD_MRS:  dly_m1 = CW'(CYCLES_MRD - 1);
      CMD_ZQCL: dly_m1 = CW'(CYCLES_ZQ - 1);
      default:  dly_m1 = '0;
    endcase
  end

  // Only PRE/REF wait for write recovery; other commands may go to other banks.
  assign wr_block  = ((ddl_cmd_i == CMD_PRE) || (ddl_cmd_i == CMD_REF)) && (wr_cnt_q != '0);
  assign ddl_rdy_o = reset_n && (state_q == ST_IDLE) && !wr_block;
  assign accept    = ddl_req_i && ddl_rdy_o;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_cnt_d = (wr_cnt_q != '0) ? (wr_cnt_q - CNT_ONE) : '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (dly_m1 != '0)) begin
          cnt_d   = dly_m1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept && (ddl_cmd_i == CMD_WR)) begin
      wr_cnt_d = CW'(CYCLES_WR - 1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Pins default to NOP each cycle; ba/adr/tid hold between commands.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dfi_cs_n_o  <= 1'b1;
      dfi_ras_n_o <= 1'b1;
      dfi_cas_n_o <= 1'b1;
      dfi_we_n_o  <= 1'b1;
      dfi_ba_o    <= '0;
      dfi_adr_o   <= '0;
      dfi_rden_o  <= 1'b0;
      dfi_wren_o  <= 1'b0;
      dfi_tid_o   <= '0;
    end else begin
      dfi_cs_n_o  <= 1'b1;
      dfi_ras_n_o <= 1'b1;
      dfi_cas_n_o <= 1'b1;
      dfi_we_n_o  <= 1'b1;
      dfi_rden_o  <= 1'b0;
      dfi_wren_o  <= 1'b0;
      if (accept) begin
        dfi_cs_n_o  <= (ddl_cmd_i == CMD_NOP);
        dfi_ras_n_o <= ddl_cmd_i[2];
        dfi_cas_n_o <= ddl_cmd_i[1];
        dfi_we_n_o  <= ddl_cmd_i[0];
        dfi_ba_o    <= ddl_ba_i;
        dfi_adr_o   <= ddl_adr_i;
        if (ddl_cmd_i == CMD_RD) begin
          dfi_rden_o <= 1'b1;
          dfi_tid_o  <= ddl_tid_i;
        end
        if (ddl_cmd_i == CMD_WR) begin
          dfi_wren_o <= 1'b1;
          dfi_tid_o  <= ddl_tid_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr3_ddl_cmd.sv
// tb/tb_ddr3_ddl_cmd.sv - directed self-checking bench for ddr3_ddl_cmd
module tb_ddr3_ddl_cmd;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req;
  logic        rdy;
  logic [2:0]  cmd;
  logic [3:0]  tid;
  logic [2:0]  ba;
  logic [12:0] adr;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [2:0]  dba;
  logic [12:0] dadr;
  logic        rden, wren;
  logic [3:0]  dtid;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
  localparam logic [2:0] PRE = 3'b010, REF = 3'b001, ZQCL = 3'b110;

  ddr3_ddl_cmd dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ddl_req_i   (req),
    .ddl_rdy_o   (rdy),
    .ddl_cmd_i   (cmd),
    .ddl_tid_i   (tid),
    .ddl_ba_i    (ba),
    .ddl_adr_i   (adr),
    .dfi_cs_n_o  (cs_n),
    .dfi_ras_n_o (ras_n),
    .dfi_cas_n_o (cas_n),
    .dfi_we_n_o  (we_n),
    .dfi_ba_o    (dba),
    .dfi_adr_o   (dadr),
    .dfi_rden_o  (rden),
    .dfi_wren_o  (wren),
    .dfi_tid_o   (dtid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_n = edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer a command until accepted (bounded); returns the accepting edge index.
  task automatic send(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a,
                      input logic [3:0] t, input int bound, output int acc);
    cmd = c; ba = b; adr = a; tid = t; req = 1'b1;
    acc = -1;
    for (int i = 0; i < bound; i++) begin
      #1;
      if (rdy) begin
        acc = edge_n + 1;
        step();
        break;
      end
      step();
    end
    req = 1'b0;
    chk("accept_in_bound", (acc != -1), 1);
  endtask

  task automatic check_pins(input string tag, input logic [2:0] c, input logic [2:0] b,
                            input logic [12:0] a, input logic rd, input logic wr, input logic [3:0] t);
    chk({tag, "_cs_n"}, cs_n, 0);
    chk({tag, "_cmd"}, {ras_n, cas_n, we_n}, c);
    chk({tag, "_ba"}, dba, b);
    chk({tag, "_adr"}, dadr, a);
    chk({tag, "_rden"}, rden, rd);
    chk({tag, "_wren"}, wren, wr);
    chk({tag, "_tid"}, dtid, t);
  endtask

  initial begin
    int a0, a1, r1, r2, w0, p0, rf, zq, nx, e_rel, n0, n1;

    // Reset held with a valid ACT offered: nothing reaches the pins.
    reset_n = 1'b0; req = 1'b1; cmd = ACT; tid = 4'd0; ba = 3'd1; adr = 13'h001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_cs_n", cs_n, 1);
      chk("rst_rdy", rdy, 0);
    end
    chk("rst_ba", dba, 0);
    chk("rst_adr", dadr, 0);
    chk("rst_tid", dtid, 0);
    chk("rst_strobes", {rden, wren}, 0);
    reset_n = 1'b1;
    #1;
    chk("rdy_after_release", rdy, 1);
    req = 1'b0;
    step();
    chk("idle_no_req_cs_n", cs_n, 1);

    // ACT then RD: RCD spacing of 2.
    send(ACT, 3'd2, 13'h155, 4'd0, 4, a0);
    check_pins("act", ACT, 3'd2, 13'h155, 0, 0, 4'd0);
    send(RD, 3'd2, 13'h008, 4'd5, 6, a1);
    chk("act_rd_gap", a1 - a0, 2);
    check_pins("rd5", RD, 3'd2, 13'h008, 1, 0, 4'd5);
    step();
    chk("rd5_rden_drop", rden, 0);
    chk("rd5_cs_n_drop", cs_n, 1);
    chk("rd5_tid_hold", dtid, 5);

    // RD, RD, WR back-to-back: CCD spacing of 4.
    send(RD, 3'd2, 13'h010, 4'd1, 8, r1);
    chk("rd_rd_gap0", r1 - a1, 4);
    check_pins("rd1", RD, 3'd2, 13'h010, 1, 0, 4'd1);
    send(RD, 3'd2, 13'h018, 4'd2, 8, r2);
    chk("rd_rd_gap1", r2 - r1, 4);
    check_pins("rd2", RD, 3'd2, 13'h018, 1, 0, 4'd2);
    send(WR, 3'd2, 13'h020, 4'd3, 8, w0);
    chk("rd_wr_gap", w0 - r2, 4);
    check_pins("wr3", WR, 3'd2, 13'h020, 0, 1, 4'd3);

    // Write recovery: PRE blocked until w0+10, ACT elsewhere passes at w0+4.
    cmd = PRE; ba = 3'd2; adr = 13'h400; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wr_spacing_rdy", rdy, 0);
      step();
    end
    #1;
    chk("pre_blocked_by_wr", rdy, 0);
    send(ACT, 3'd5, 13'h0aa, 4'd0, 4, n0);
    chk("act_other_bank_edge", n0 - w0, 4);
    check_pins("act5", ACT, 3'd5, 13'h0aa, 0, 0, 4'd3);
    send(PRE, 3'd2, 13'h400, 4'd0, 12, p0);
    chk("pre_after_wr_edge", p0 - w0, 10);
    check_pins("pre", PRE, 3'd2, 13'h400, 0, 0, 4'd3);

    // REF -> ZQCL -> ACT: RFC then ZQ spacing.
    send(REF, 3'd0, 13'h000, 4'd0, 4, rf);
    chk("pre_ref_gap", rf - p0, 2);
    check_pins("ref", REF, 3'd0, 13'h000, 0, 0, 4'd3);
    send(ZQCL, 3'd0, 13'h400, 4'd0, 20, zq);
    chk("ref_zq_gap", zq - rf, 11);
    check_pins("zq", ZQCL, 3'd0, 13'h400, 0, 0, 4'd3);
    step();
    chk("zq_pins_nop", cs_n, 1);
    send(ACT, 3'd1, 13'h0f0, 4'd0, 80, nx);
    chk("zq_act_gap", nx - zq, 64);

    // NOP accepted: no cs_n pulse, next command back-to-back.
    step();
    send(NOP, 3'd0, 13'h000, 4'd0, 4, n0);
    chk("nop_cs_n", cs_n, 1);
    send(RD, 3'd1, 13'h004, 4'd9, 4, n1);
    chk("nop_rd_gap", n1 - n0, 1);
    check_pins("rd9", RD, 3'd1, 13'h004, 1, 0, 4'd9);

    // Reset 3 cycles into REF spacing clears the wait.
    send(REF, 3'd0, 13'h000, 4'd0, 8, rf);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk("rdy_in_reset", rdy, 0);
    step();
    chk("reset_cs_n", cs_n, 1);
    reset_n = 1'b1;
    e_rel = edge_n;
    send(ACT, 3'd3, 13'h123, 4'd0, 4, n0);
    chk("act_after_reset_edge", n0 - e_rel, 1);

    // Reset also clears write recovery.
    send(WR, 3'd3, 13'h040, 4'd7, 4, w0);
    chk("wr7_strobe", wren, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    e_rel = edge_n;
    send(PRE, 3'd3, 13'h000, 4'd0, 4, p0);
    chk("pre_after_reset_edge", p0 - e_rel, 1);
    check_pins("pre_rst", PRE, 3'd3, 13'h000, 0, 0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
